// File: rtl/imem_fetch.sv
// -----------------------------------------------------------------------------
// imem_fetch
// Instruction fetch stage. Drives the word address of a combinational
// instruction ROM, stores each returned word with its byte PC in a small
// prefetch FIFO and hands the FIFO head to decode over valid/ready.
// A branch redirect flushes the FIFO and restarts fetch at the new PC.
//
// Optional feature macro: FETCH_HALT_EN
//   defined   : a zero ROM word is not enqueued; fetch parks in HALT with the
//               PC frozen until redirect or reset. Adds output 'halted'.
//   undefined : zero words are fetched like any other instruction.
//
// Ports
//   clk          in   1     system clock, rising edge
//   reset        in   1     asynchronous, active-low reset
//   imem_addr    out  6     ROM word address = pc[7:2]
//   imem_q       in   SIZE  ROM read data (combinational from imem_addr)
//   instr_valid  out  1     FIFO head is valid
//   instr_ready  in   1     decode accepts the head this cycle
//   instr_out    out  SIZE  instruction word at FIFO head
//   instr_pc     out  N     byte PC of the head instruction
//   redirect     in   1     branch taken: flush and refetch
//   redirect_pc  in   N     new byte PC, bits [1:0] forced to zero
//   fetch_count  out  CW    FIFO occupancy, 0..DEPTH
//   halted       out  1     (FETCH_HALT_EN only) fetch is parked in HALT
//
// HALT FSM (FETCH_HALT_EN only)
//   state    | meaning
//   ST_FETCH | normal fetch, one word per cycle when the FIFO has room
//   ST_HALT  | zero word seen; pc frozen, FIFO drains, wait for redirect
// -----------------------------------------------------------------------------
module imem_fetch #(
  parameter int N     = 64,
  parameter int SIZE  = 32,
  parameter int DEPTH = 4,
  localparam int AW   = $clog2(DEPTH),
  localparam int CW   = $clog2(DEPTH) + 1
) (
  input  logic            clk,
  input  logic            reset,
  output logic [5:0]      imem_addr,
  input  logic [SIZE-1:0] imem_q,
  output logic            instr_valid,
  input  logic            instr_ready,
  output logic [SIZE-1:0] instr_out,
  output logic [N-1:0]    instr_pc,
  input  logic            redirect,
  input  logic [N-1:0]    redirect_pc,
  output logic [CW-1:0]   fetch_count
`ifdef FETCH_HALT_EN
  ,
  output logic            halted
`endif
);

  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  logic [N-1:0]    r_pc;
  logic [SIZE-1:0] r_mem_instr [DEPTH];
  logic [N-1:0]    r_mem_pc    [DEPTH];
  logic [AW-1:0]   r_wptr;
  logic [AW-1:0]   r_rptr;
  logic [CW-1:0]   r_count;

  logic            w_fetch_en;
  logic            w_not_empty;
  logic            w_pop;
  logic            w_push;
  logic [N-1:0]    w_redir_pc;

  // Masking keeps every redirect_pc bit in use while forcing word alignment.
  assign w_redir_pc  = redirect_pc & ~N'(3);

  assign w_not_empty = (r_count != '0);
  assign w_pop       = w_not_empty && instr_ready && !redirect;
  // Full FIFO may still accept a word when the head leaves in the same cycle.
  assign w_push      = !redirect && w_fetch_en && ((r_count < DEPTH_C) || w_pop);

  assign imem_addr   = r_pc[7:2];
  assign instr_valid = w_not_empty && !redirect;
  assign instr_out   = r_mem_instr[r_rptr];
  assign instr_pc    = r_mem_pc[r_rptr];
  assign fetch_count = r_count;

`ifdef FETCH_HALT_EN
  typedef enum logic {ST_FETCH, ST_HALT} state_t;
  state_t r_state;
  state_t w_state_nxt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= ST_FETCH;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_fetch_en  = 1'b0;
    case (r_state)
      ST_FETCH: begin
        w_fetch_en = (imem_q != '0);
        if (!redirect && (imem_q == '0)) w_state_nxt = ST_HALT;
      end
      ST_HALT: begin
        if (redirect) w_state_nxt = ST_FETCH;
      end
      default: w_state_nxt = ST_FETCH;
    endcase
  end

  assign halted = (r_state == ST_HALT);
`else
  assign w_fetch_en = 1'b1;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_pc <= '0;
    end else if (redirect) begin
      r_pc <= w_redir_pc;
    end else if (w_push) begin
      r_pc <= r_pc + N'(4);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else if (redirect) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + AW'(1);
      if (w_pop)  r_rptr <= r_rptr + AW'(1);
      r_count <= r_count + CW'(w_push) - CW'(w_pop);
    end
  end

  // Storage is reset so the head outputs read zero straight out of reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem_instr[i] <= '0;
        r_mem_pc[i]    <= '0;
      end
    end else if (w_push) begin
      r_mem_instr[r_wptr] <= imem_q;
      r_mem_pc[r_wptr]    <= r_pc;
    end
  end

endmodule

// File: tb/tb_imem_fetch.sv
module tb_imem_fetch;
  localparam int N     = 64;
  localparam int SIZE  = 32;
  localparam int DEPTH = 4;

  logic            clk = 1'b0;
  logic            reset = 1'b0;
  logic [5:0]      imem_addr;
  logic [SIZE-1:0] imem_q;
  logic            instr_valid;
  logic            instr_ready = 1'b0;
  logic [SIZE-1:0] instr_out;
  logic [N-1:0]    instr_pc;
  logic            redirect = 1'b0;
  logic [N-1:0]    redirect_pc = '0;
  logic [2:0]      fetch_count;
`ifdef FETCH_HALT_EN
  logic            halted;
`endif

  imem_fetch #(.N(N), .SIZE(SIZE), .DEPTH(DEPTH)) dut (
    .clk         (clk),
    .reset       (reset),
    .imem_addr   (imem_addr),
    .imem_q      (imem_q),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .instr_out   (instr_out),
    .instr_pc    (instr_pc),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .fetch_count (fetch_count)
`ifdef FETCH_HALT_EN
    ,
    .halted      (halted)
`endif
  );

  always #5 clk = ~clk;

  logic [SIZE-1:0] rom [64];
  assign imem_q = rom[imem_addr];

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  typedef struct {
    bit          rst;
    bit          redir;
    logic [63:0] rpc;
    bit          rdy;
    bit          e_valid;
    logic [63:0] e_pc;
    logic [31:0] e_instr;
    logic [2:0]  e_cnt;
    logic [5:0]  e_addr;
    bit          e_halt;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(bit rst, bit redir, logic [63:0] rpc, bit rdy, bit e_valid,
                              logic [63:0] e_pc, logic [31:0] e_instr, logic [2:0] e_cnt,
                              logic [5:0] e_addr, bit e_halt);
    vec_t v;
    v.rst = rst; v.redir = redir; v.rpc = rpc; v.rdy = rdy; v.e_valid = e_valid;
    v.e_pc = e_pc; v.e_instr = e_instr; v.e_cnt = e_cnt; v.e_addr = e_addr; v.e_halt = e_halt;
    return v;
  endfunction

  // Reset pulse between negedges; returns just after a negedge with reset released.
  task automatic do_reset();
    redirect = 1'b0; redirect_pc = '0; instr_ready = 1'b0;
    @(negedge clk) reset = 1'b0;
    @(negedge clk);
    @(negedge clk) reset = 1'b1;
  endtask

  initial begin
    for (int i = 0; i < 64; i++) rom[i] = 32'hf800_0000 + 32'(i) * 32'h0000_8001;
    rom[6'h0E] = 32'hcb0e01ce;
    rom[6'h0F] = 32'hb400004e;
    rom[6'h12] = 32'hf803800f;
    rom[6'h13] = 32'h0000_0000;

    // basic streaming from reset
    vecs.push_back(mk(1, 0, 0, 1, 0, 0, 0, 0, 6'h00, 0));
    vecs.push_back(mk(0, 0, 0, 1, 1, 64'h0, 32'hf8000000, 1, 6'h01, 0));
    vecs.push_back(mk(0, 0, 0, 1, 1, 64'h4, 32'hf8008001, 1, 6'h02, 0));
    vecs.push_back(mk(0, 0, 0, 1, 1, 64'h8, 32'hf8010002, 1, 6'h03, 0));
    // backpressure fills FIFO, then pc holds
    vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 6'h00, 0));
    vecs.push_back(mk(0, 0, 0, 0, 1, 64'h0, 32'hf8000000, 1, 6'h01, 0));
    vecs.push_back(mk(0, 0, 0, 0, 1, 64'h0, 32'hf8000000, 2, 6'h02, 0));
    vecs.push_back(mk(0, 0, 0, 0, 1, 64'h0, 32'hf8000000, 3, 6'h03, 0));
    vecs.push_back(mk(0, 0, 0, 0, 1, 64'h0, 32'hf8000000, 4, 6'h04, 0));
    vecs.push_back(mk(0, 0, 0, 0, 1, 64'h0, 32'hf8000000, 4, 6'h04, 0));
    vecs.push_back(mk(0, 0, 0, 0, 1, 64'h0, 32'hf8000000, 4, 6'h04, 0));
    vecs.push_back(mk(0, 0, 0, 0, 1, 64'h0, 32'hf8000000, 4, 6'h04, 0));
    // release: full FIFO with push+pop each cycle
    vecs.push_back(mk(0, 0, 0, 1, 1, 64'h00, 32'hf8000000, 4, 6'h04, 0));
    vecs.push_back(mk(0, 0, 0, 1, 1, 64'h04, 32'hf8008001, 4, 6'h05, 0));
    vecs.push_back(mk(0, 0, 0, 1, 1, 64'h08, 32'hf8010002, 4, 6'h06, 0));
    vecs.push_back(mk(0, 0, 0, 1, 1, 64'h0C, 32'hf8018003, 4, 6'h07, 0));
    vecs.push_back(mk(0, 0, 0, 1, 1, 64'h10, 32'hf8020004, 4, 6'h08, 0));
    // misaligned redirect while full
    vecs.push_back(mk(0, 1, 64'h3B, 1, 0, 0, 0, 4, 6'h09, 0));
    vecs.push_back(mk(0, 0, 0, 1, 0, 0, 0, 0, 6'h0E, 0));
    vecs.push_back(mk(0, 0, 0, 1, 1, 64'h38, 32'hcb0e01ce, 1, 6'h0F, 0));
    vecs.push_back(mk(0, 0, 0, 1, 1, 64'h3C, 32'hb400004e, 1, 6'h10, 0));
    // redirect held two cycles: each reloads pc, nothing enqueued
    vecs.push_back(mk(0, 1, 64'h44, 1, 0, 0, 0, 1, 6'h11, 0));
    vecs.push_back(mk(0, 1, 64'h48, 1, 0, 0, 0, 0, 6'h11, 0));
    vecs.push_back(mk(0, 0, 0, 1, 0, 0, 0, 0, 6'h12, 0));
    vecs.push_back(mk(0, 0, 0, 1, 1, 64'h48, 32'hf803800f, 1, 6'h13, 0));
`ifdef FETCH_HALT_EN
    vecs.push_back(mk(0, 0, 0, 1, 0, 0, 0, 0, 6'h13, 1));
    vecs.push_back(mk(0, 1, 64'hFFFF_FFFF_FFFF_FFFF, 1, 0, 0, 0, 0, 6'h13, 1));
`else
    vecs.push_back(mk(0, 0, 0, 1, 1, 64'h4C, 32'h00000000, 1, 6'h14, 0));
    vecs.push_back(mk(0, 1, 64'hFFFF_FFFF_FFFF_FFFF, 1, 0, 0, 0, 1, 6'h15, 0));
`endif
    // pc wraps modulo 2^N
    vecs.push_back(mk(0, 0, 0, 1, 0, 0, 0, 0, 6'h3F, 0));
    vecs.push_back(mk(0, 0, 0, 1, 1, 64'hFFFF_FFFF_FFFF_FFFC, 32'hf81f803f, 1, 6'h00, 0));
    vecs.push_back(mk(0, 0, 0, 1, 1, 64'h0, 32'hf8000000, 1, 6'h01, 0));

    // reset state while reset is held
    #12;
    chk("rst_valid", 64'(instr_valid), 64'h0);
    chk("rst_count", 64'(fetch_count), 64'h0);
    chk("rst_instr", 64'(instr_out), 64'h0);
    chk("rst_pc",    instr_pc, 64'h0);
    chk("rst_addr",  64'(imem_addr), 64'h0);

    foreach (vecs[k]) begin
      if (vecs[k].rst) do_reset();
      redirect    = vecs[k].redir;
      redirect_pc = vecs[k].rpc;
      instr_ready = vecs[k].rdy;
      #1;
      chk($sformatf("v%0d_valid", k), 64'(instr_valid), 64'(vecs[k].e_valid));
      chk($sformatf("v%0d_count", k), 64'(fetch_count), 64'(vecs[k].e_cnt));
      chk($sformatf("v%0d_addr", k),  64'(imem_addr),   64'(vecs[k].e_addr));
      if (vecs[k].e_valid) begin
        chk($sformatf("v%0d_pc", k),    instr_pc,        vecs[k].e_pc);
        chk($sformatf("v%0d_instr", k), 64'(instr_out),  64'(vecs[k].e_instr));
      end
`ifdef FETCH_HALT_EN
      chk($sformatf("v%0d_halted", k), 64'(halted), 64'(vecs[k].e_halt));
`endif
      @(negedge clk);
    end

    // asynchronous reset mid-stream with three entries queued
    do_reset();
    instr_ready = 1'b0;
    repeat (3) @(negedge clk);
    chk("mid_count_before", 64'(fetch_count), 64'h3);
    #2 reset = 1'b0;
    #1;
    chk("mid_valid", 64'(instr_valid), 64'h0);
    chk("mid_count", 64'(fetch_count), 64'h0);
    chk("mid_instr", 64'(instr_out),   64'h0);
    chk("mid_pc",    instr_pc,         64'h0);
    chk("mid_addr",  64'(imem_addr),   64'h0);
    @(negedge clk) reset = 1'b1;
    instr_ready = 1'b1;
    #1;
    chk("restart_valid0", 64'(instr_valid), 64'h0);
    chk("restart_addr0",  64'(imem_addr),   64'h0);
    @(negedge clk);
    #1;
    chk("restart_valid1", 64'(instr_valid), 64'h1);
    chk("restart_pc1",    instr_pc,         64'h0);
    chk("restart_instr1", 64'(instr_out),   64'hf8000000);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
